// File: rtl/mmio_timer_pkg.sv
// Shared register map and bit positions for the mmio_timer peripheral.
// Latency: none (constants and a decode helper only).
// Backpressure: not applicable.
package mmio_timer_pkg;

    localparam logic [4:0] OFS_CTRL     = 5'h00;
    localparam logic [4:0] OFS_PRESCALE = 5'h04;
    localparam logic [4:0] OFS_COMPARE  = 5'h08;
    localparam logic [4:0] OFS_COUNT    = 5'h0C;
    localparam logic [4:0] OFS_STATUS   = 5'h10;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQEN      = 2;
    localparam int CTRL_OVFIE      = 3;

    localparam int ST_MATCH = 0;
    localparam int ST_OVF   = 1;

    typedef logic [2:0] word_idx_t;

    // Byte offsets [1:0] are ignored; registers are selected by word index.
    function automatic word_idx_t word_idx(input logic [4:0] ofs);
        return ofs[4:2];
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk into single-cycle ticks, one every (limit+1) enabled cycles.
// Latency: tick is combinational from the registered count and en.
// Backpressure: none; disabled state freezes the count, clr restarts it.
module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] limit,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;

    assign tick = en && (pcnt == limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (clr || tick) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= pcnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled up-counter with compare match and level irq; overflow flag under MMIO_TIMER_OVF_EN.
// Latency: register writes take effect on the clk edge; hit/rdata are combinational from memaddr.
// Backpressure: none; every store and load completes in its own cycle.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        irq
);

    logic                  en;
    logic                  autoreload;
    logic                  irqen;
    logic [PRESCALE_W-1:0] prescale;
    logic [31:0]           compare;
    logic [31:0]           count;
    logic                  match;
    logic                  ovf;
    logic                  ovfie;

    logic        tick;
    logic        wr;
    word_idx_t   widx;
    logic        wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
    logic        cnt_eq;
    logic [31:0] cnt_inc;
    logic        match_set;
    logic        unused_byte_ofs;

    assign hit             = (memaddr[31:5] == BASE_ADDR[31:5]);
    assign wr              = memwrite && hit;
    assign widx            = word_idx(memaddr[4:0]);
    assign unused_byte_ofs = ^memaddr[1:0];

    assign wr_ctrl     = wr && (widx == word_idx(OFS_CTRL));
    assign wr_prescale = wr && (widx == word_idx(OFS_PRESCALE));
    assign wr_compare  = wr && (widx == word_idx(OFS_COMPARE));
    assign wr_count    = wr && (widx == word_idx(OFS_COUNT));
    assign wr_status   = wr && (widx == word_idx(OFS_STATUS));

    assign cnt_eq    = (count == compare);
    assign cnt_inc   = count + 32'd1;
    assign match_set = tick && cnt_eq;

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (wr_prescale),
        .limit (prescale),
        .tick  (tick)
    );

    // Later assignments override the tick update: software writes win over
    // the counter's own next value and over the one-shot en clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            en         <= 1'b0;
            autoreload <= 1'b0;
            irqen      <= 1'b0;
            prescale   <= '0;
            compare    <= 32'hFFFFFFFF;
            count      <= '0;
            match      <= 1'b0;
        end else begin
            if (tick) begin
                if (cnt_eq && autoreload) begin
                    count <= '0;
                end else begin
                    count <= cnt_inc;
                end
                if (cnt_eq && !autoreload) begin
                    en <= 1'b0;
                end
            end
            if (wr_ctrl) begin
                en         <= memwritedata[CTRL_EN];
                autoreload <= memwritedata[CTRL_AUTORELOAD];
                irqen      <= memwritedata[CTRL_IRQEN];
            end
            if (wr_prescale) begin
                prescale <= memwritedata[PRESCALE_W-1:0];
            end
            if (wr_compare) begin
                compare <= memwritedata;
            end
            if (wr_count) begin
                count <= memwritedata;
            end
            match <= match_set || (match && !(wr_status && memwritedata[ST_MATCH]));
        end
    end

`ifdef MMIO_TIMER_OVF_EN
    logic ovf_set;

    // A wrap is an increment from all-ones; a match reload to 0 is not a wrap.
    assign ovf_set = tick && (count == 32'hFFFFFFFF) && !(cnt_eq && autoreload);

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf   <= 1'b0;
            ovfie <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ovfie <= memwritedata[CTRL_OVFIE];
            end
            ovf <= ovf_set || (ovf && !(wr_status && memwritedata[ST_OVF]));
        end
    end
`else
    assign ovf   = 1'b0;
    assign ovfie = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (widx)
            word_idx(OFS_CTRL): begin
                rdata[CTRL_EN]         = en;
                rdata[CTRL_AUTORELOAD] = autoreload;
                rdata[CTRL_IRQEN]      = irqen;
                rdata[CTRL_OVFIE]      = ovfie;
            end
            word_idx(OFS_PRESCALE): rdata[PRESCALE_W-1:0] = prescale;
            word_idx(OFS_COMPARE):  rdata = compare;
            word_idx(OFS_COUNT):    rdata = count;
            word_idx(OFS_STATUS): begin
                rdata[ST_MATCH] = match;
                rdata[ST_OVF]   = ovf;
            end
            default: rdata = '0;
        endcase
    end

    assign irq = (match && irqen) || (ovf && ovfie);

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: a register-level reference model predicts every load and irq.
// Stimulus and checking are decoupled; the monitor samples on the falling edge.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'hFFFF0000;
    localparam int          PW   = 16;
`ifdef MMIO_TIMER_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] memaddr = BASE;
    logic [31:0] memwritedata = '0;
    logic        hit;
    logic [31:0] rdata;
    logic        irq;

    always #5 clk = ~clk;

    mmio_timer #(
        .BASE_ADDR  (BASE),
        .PRESCALE_W (PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
        .hit          (hit),
        .rdata        (rdata),
        .irq          (irq)
    );

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        logic        hit;
        bit          chk_rd;
        int          tag;
    } exp_t;

    exp_t sb[$];
    logic chk_vld = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   tag = 0;

    // Reference model: architectural register values plus the prescale phase.
    bit          m_en, m_ar, m_ie, m_oie, m_match, m_ovf;
    int unsigned m_pre, m_pc;
    logic [31:0] m_cmp, m_cnt;

    task automatic m_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_oie = 0; m_match = 0; m_ovf = 0;
        m_pre = 0; m_pc = 0; m_cmp = 32'hFFFFFFFF; m_cnt = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] ofs);
        case (int'(ofs) / 4)
            0: return {28'd0, m_oie, m_ie, m_ar, m_en};
            1: return m_pre;
            2: return m_cmp;
            3: return m_cnt;
            4: return {30'd0, m_ovf, m_match};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_irq();
        return (m_match && m_ie) || (m_ovf && m_oie);
    endfunction

    task automatic m_edge(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit          wr, tick, is_match, wraps;
        int          w;
        bit          n_en, n_match, n_ovf;
        logic [31:0] n_cnt;
        int unsigned n_pc;
        wr       = we && (a[31:5] == BASE[31:5]);
        w        = wr ? int'(a[4:0]) / 4 : -1;
        tick     = m_en && (m_pc == m_pre);
        is_match = tick && (m_cnt == m_cmp);
        wraps    = tick && (m_cnt == 32'hFFFFFFFF) && !(is_match && m_ar);
        n_en = m_en; n_cnt = m_cnt;
        if (tick) n_cnt = (is_match && m_ar) ? 32'd0 : m_cnt + 32'd1;
        if (is_match && !m_ar) n_en = 0;
        n_pc    = (w == 1 || tick) ? 0 : (m_en ? m_pc + 1 : m_pc);
        n_match = is_match || (m_match && !(w == 4 && d[0]));
        n_ovf   = OVF && (wraps || (m_ovf && !(w == 4 && d[1])));
        case (w)
            0: begin n_en = d[0]; m_ar = d[1]; m_ie = d[2]; m_oie = OVF && d[3]; end
            1: m_pre = d % (1 << PW);
            2: m_cmp = d;
            3: n_cnt = d;
            default: ;
        endcase
        m_en = n_en; m_cnt = n_cnt; m_pc = n_pc; m_match = n_match; m_ovf = n_ovf;
    endtask

    // One bus cycle: drive, predict the combinational response, then step the model at the edge.
    task automatic cyc_a(input bit we, input logic [31:0] a, input logic [31:0] d, input bit chk);
        exp_t e;
        memwrite = we; memaddr = a; memwritedata = d; chk_vld = chk;
        if (chk) begin
            e.hit = (a[31:5] == BASE[31:5]);
            e.rd = m_read(a[4:0]); e.irq = m_irq(); e.chk_rd = e.hit; e.tag = tag;
            sb.push_back(e);
            tag++;
        end
        @(posedge clk);
        if (reset) m_reset();
        else m_edge(we, a, d);
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] ofs, input logic [31:0] d);
        cyc_a(1'b1, BASE + {27'd0, ofs}, d, 1'b1);
    endtask

    task automatic rd_reg(input logic [4:0] ofs);
        cyc_a(1'b0, BASE + {27'd0, ofs}, 32'd0, 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (chk_vld) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb_empty: monitor found no expectation, got rdata=%h", rdata);
            end else begin
                e = sb.pop_front();
                n_chk++;
                if (hit !== e.hit) begin
                    n_fail++;
                    $display("FAIL hit tag=%0d addr=%h got=%b want=%b", e.tag, memaddr, hit, e.hit);
                end
                if (e.chk_rd) begin
                    n_chk++;
                    if (rdata !== e.rd) begin
                        n_fail++;
                        $display("FAIL rdata tag=%0d addr=%h got=%h want=%h", e.tag, memaddr, rdata, e.rd);
                    end
                end
                n_chk++;
                if (irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL irq tag=%0d got=%b want=%b", e.tag, irq, e.irq);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  ofs;
        logic [31:0] d;
        int          r;
        m_reset();
        repeat (3) cyc_a(1'b0, BASE, 32'd0, 1'b0);
        reset = 1'b0;

        // Reset values, reserved words and address decode.
        for (int i = 0; i < 8; i++) rd_reg(5'(i * 4));
        cyc_a(1'b0, 32'hFFFEFFFC, 32'd0, 1'b1);
        rd_reg(5'h0E);

        // Autoreload: prescale 3, compare 5.
        wr_reg(5'h04, 32'd3);
        wr_reg(5'h08, 32'd5);
        wr_reg(5'h00, 32'h7);
        for (int i = 0; i < 40; i++) rd_reg((i % 2) ? 5'h10 : 5'h0C);

        // One-shot: counter stops at compare+1 with en cleared.
        wr_reg(5'h00, 32'h0);
        wr_reg(5'h10, 32'h1);
        wr_reg(5'h0C, 32'h0);
        wr_reg(5'h04, 32'd3);
        wr_reg(5'h00, 32'h5);
        for (int i = 0; i < 50; i++) rd_reg((i % 3 == 0) ? 5'h00 : 5'h0C);
        for (int i = 0; i < 20; i++) rd_reg(5'h0C);

        // W1C clear, then W1C colliding with a match set.
        wr_reg(5'h10, 32'h1);
        rd_reg(5'h10);
        wr_reg(5'h00, 32'h0);
        wr_reg(5'h0C, 32'h0);
        wr_reg(5'h04, 32'h0);
        wr_reg(5'h08, 32'd2);
        wr_reg(5'h00, 32'h7);
        rd_reg(5'h0C);
        rd_reg(5'h0C);
        wr_reg(5'h10, 32'h1);
        rd_reg(5'h10);

        // COUNT write on a tick edge wins over the increment.
        wr_reg(5'h08, 32'h100);
        wr_reg(5'h0C, 32'h10);
        rd_reg(5'h0C);

        // Wrap from all-ones: ovf only when the feature is built in.
        wr_reg(5'h00, 32'h0);
        wr_reg(5'h10, 32'h3);
        wr_reg(5'h04, 32'h0);
        wr_reg(5'h08, 32'h100);
        wr_reg(5'h0C, 32'hFFFFFFFE);
        wr_reg(5'h00, 32'hD);
        rd_reg(5'h0C);
        rd_reg(5'h0C);
        rd_reg(5'h10);
        rd_reg(5'h00);

        // Randomised mix of writes, misses and reads.
        for (int i = 0; i < 400; i++) begin
            r   = $urandom_range(0, 9);
            ofs = 5'($urandom_range(0, 7) * 4);
            case (int'(ofs) / 4)
                0: d = $urandom & 32'hF;
                1: d = $urandom_range(0, 3);
                2: d = $urandom_range(0, 12);
                3: d = $urandom_range(0, 1) ? 32'($urandom_range(0, 10)) : 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
                4: d = $urandom & 32'h3;
                default: d = $urandom;
            endcase
            if (r < 3) wr_reg(ofs, d);
            else if (r == 3) cyc_a(1'b1, BASE - 32'h20 + {27'd0, ofs}, d, 1'b1);
            else rd_reg(ofs);
        end

        // Reset asserted mid-count.
        wr_reg(5'h04, 32'h0);
        wr_reg(5'h00, 32'h7);
        rd_reg(5'h0C);
        reset = 1'b1;
        cyc_a(1'b0, BASE, 32'd0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) rd_reg(5'(i * 4));

        chk_vld = 1'b0;
        @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: leftover=%0d want=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
